jogador_automatico: RTL and testbench
=====================================

Name: jogador_automatico

Overview:
- Hardware auto-player that sits on the far side of the game's player interface and plays the memory game unattended.
- Watches the game's `leds` during sequence presentation and records each shown value into an internal buffer.
- When `vez_jogador` asserts, replays the buffer on `botoes` as timed presses; in modo2 it also appends one new value per round.
- Used for FPGA self-demo and for closed-loop on-board verification of the game core.

Parameters:
- MAX_JOGADAS, 16, buffer depth (maximum sequence length).
- HOLD_CYCLES, 3, clock cycles each press is held on `botoes`.
- GAP_CYCLES, 2503, clock cycles `botoes`=0000 between presses.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- habilitar  in  1  level; 0 forces OCIOSO next cycle; buffer retained.
- leds  in  4  game LED output, one-hot or 0000.
- vez_jogador  in  1  game signals it is the player's turn.
- nova_jogada  in  1  game (modo2) requests a new move to be appended.
- modo2  in  1  game mode; sampled on OCIOSO->CAPTURA.
- novo_valor  in  4  one-hot value pressed and appended on a nova_jogada request.
- botoes  out  4  button presses to the game.
- ocupado  out  1  high in any state except OCIOSO.
- erro_captura  out  1  sticky; cleared only by reset.
- db_indice  out  5  current capture/replay index.
- db_estado  out  4  state code.

Behaviour:
- Reset (async, reset=0): state OCIOSO. botoes=0000, erro_captura=0, indices=0, buffer contents undefined, all outputs 0.
- State codes: OCIOSO=0, CAPTURA=1, PRESSIONA=2, INTERVALO=3, ESPERA_NOVA=4, PRESSIONA_NOVA=5, INTERVALO_NOVA=6.
- All inputs are registered once. All timing below is relative to the registered copies.
- OCIOSO:
  - habilitar=1 -> CAPTURA.
  - Latch modo2.
  - cap_idx=0.
- CAPTURA:
  - Detect a rising edge of `leds`, i.e. previous 0000 and current !=0000.
  - One-hot value with cap_idx<MAX_JOGADAS: buffer[cap_idx]=leds, cap_idx++.
  - Not one-hot, or cap_idx==MAX_JOGADAS: nothing stored, erro_captura=1.
  - Rising edge of vez_jogador -> PRESSIONA with rep_idx=0. If cap_idx==0, go to ESPERA_NOVA instead (modo2) or stay in CAPTURA (modo1).
- PRESSIONA: botoes=buffer[rep_idx] for exactly HOLD_CYCLES cycles -> INTERVALO.
- INTERVALO: botoes=0000 for GAP_CYCLES cycles, then rep_idx++.
  - rep_idx<cap_idx -> PRESSIONA.
  - Otherwise, modo2 -> ESPERA_NOVA.
  - Otherwise (modo1) -> CAPTURA with cap_idx cleared to 0, because the next round re-presents the whole sequence.
- ESPERA_NOVA: nova_jogada=1 -> PRESSIONA_NOVA. vez_jogador=0 for 2 consecutive cycles -> CAPTURA (buffer kept).
- PRESSIONA_NOVA: botoes=novo_valor for HOLD_CYCLES cycles.
  - Append to buffer if cap_idx<MAX_JOGADAS, else set erro_captura.
  - Then -> INTERVALO_NOVA.
- INTERVALO_NOVA: GAP_CYCLES idle, then, with rep_idx=0:
  - vez_jogador still 1 -> PRESSIONA (replay next round).
  - Otherwise -> CAPTURA.
- Capture is ignored while `botoes`!=0000 or in any replay state, so the game echoing presses on `leds` is never recorded.
- habilitar=0 mid-press: botoes=0000 on the next edge, state OCIOSO.
- Reset mid-press: botoes=0000 immediately (asynchronous).
- Press latency: first press appears 2 cycles after vez_jogador rises at the pin (1 cycle input register + 1 cycle FSM).
- Widths: cap_idx/rep_idx are clog2(MAX_JOGADAS)+1 bits and saturate at MAX_JOGADAS. Timer width is sized for max(HOLD_CYCLES, GAP_CYCLES).

Optional Feature:
- Macro: JOGADOR_ERRO_INJETADO_EN.
- Defined: adds inputs `injetar_erro` (1 bit) and `indice_erro` (5 bits).
  - While injetar_erro=1, the replay press whose rep_idx==indice_erro drives the buffer value rotated left by 1 (0001->0010, 1000->0001) instead of the stored value.
  - Used to exercise the game's perdeu path.
- Undefined: ports absent; replay always uses the stored value.

Test Plan:
- Modo1, round 1: leds shows 0001 then vez_jogador=1 -> botoes=0001 for 3 cycles starting 2 cycles after vez_jogador; db_indice ends at 1; state returns to CAPTURA.
- Modo1, 3-round sequence 0001,0100,1000: botoes pulses exactly those values, with 3 cycles on and 2503 off between presses.
- Modo2: round 1 captured as 0010; nova_jogada with novo_valor=1000 -> press 1000. Round 2 replays 0010, 1000, then presses the new value; cap_idx=3.
- Capture error cases: leds=0101 -> erro_captura=1 and nothing stored. MAX_JOGADAS+1 captures -> erro_captura=1 and cap_idx=16.
- Interruption: reset driven low mid-PRESSIONA -> botoes=0000 and db_estado=0 without waiting for a clock edge. habilitar=0 mid-INTERVALO -> OCIOSO next cycle.
- With JOGADOR_ERRO_INJETADO_EN, indice_erro=1, buffer 0001,0100: replay presses 0001 then 1000.

Source files
------------

// File: rtl/jogador_automatico.sv
// Auto-player for the memory game: records the sequence shown on leds and replays it on botoes.
// Optional JOGADOR_ERRO_INJETADO_EN adds a deliberate wrong-press injector for the replay.
module jogador_automatico #(
    parameter int MAX_JOGADAS = 16,
    parameter int HOLD_CYCLES = 3,
    parameter int GAP_CYCLES  = 2503
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       habilitar,
    input  logic [3:0] leds,
    input  logic       vez_jogador,
    input  logic       nova_jogada,
    input  logic       modo2,
    input  logic [3:0] novo_valor,
`ifdef JOGADOR_ERRO_INJETADO_EN
    input  logic       injetar_erro,
    input  logic [4:0] indice_erro,
`endif
    output logic [3:0] botoes,
    output logic       ocupado,
    output logic       erro_captura,
    output logic [4:0] db_indice,
    output logic [3:0] db_estado
);

    localparam int IW   = $clog2(MAX_JOGADAS) + 1;
    localparam int AW   = (MAX_JOGADAS > 1) ? $clog2(MAX_JOGADAS) : 1;
    localparam int TMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [IW-1:0] MAX_IDX  = IW'(MAX_JOGADAS);
    localparam logic [TW-1:0] HOLD_END = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] GAP_END  = TW'(GAP_CYCLES - 1);

    typedef enum logic [3:0] {
        OCIOSO         = 4'd0,
        CAPTURA        = 4'd1,
        PRESSIONA      = 4'd2,
        INTERVALO      = 4'd3,
        ESPERA_NOVA    = 4'd4,
        PRESSIONA_NOVA = 4'd5,
        INTERVALO_NOVA = 4'd6
    } estado_t;

    logic          habilitar_reg, vez_reg, vez_prev_reg, nova_reg, modo2_in_reg;
    logic [3:0]    leds_reg, leds_prev_reg, novo_reg;
    estado_t       state_reg, state_next;
    logic [TW-1:0] timer_reg, timer_next;
    logic [IW-1:0] cap_reg, cap_next, rep_reg, rep_next, rep_inc;
    logic [3:0]    botoes_reg, botoes_next;
    logic          erro_reg, erro_next, modo_reg, modo_next;

    logic [3:0]    buffer_mem [MAX_JOGADAS];
    logic          wr_en;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [3:0]    wr_data, rd_raw, press_val;
    logic          leds_edge, vez_edge;

    function automatic logic is_one_hot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            habilitar_reg <= 1'b0;
            leds_reg      <= 4'd0;
            leds_prev_reg <= 4'd0;
            vez_reg       <= 1'b0;
            vez_prev_reg  <= 1'b0;
            nova_reg      <= 1'b0;
            modo2_in_reg  <= 1'b0;
            novo_reg      <= 4'd0;
        end else begin
            habilitar_reg <= habilitar;
            leds_reg      <= leds;
            leds_prev_reg <= leds_reg;
            vez_reg       <= vez_jogador;
            vez_prev_reg  <= vez_reg;
            nova_reg      <= nova_jogada;
            modo2_in_reg  <= modo2;
            novo_reg      <= novo_valor;
        end
    end

`ifdef JOGADOR_ERRO_INJETADO_EN
    logic       injetar_reg;
    logic [4:0] indice_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            injetar_reg <= 1'b0;
            indice_reg  <= 5'd0;
        end else begin
            injetar_reg <= injetar_erro;
            indice_reg  <= indice_erro;
        end
    end

    assign press_val = (injetar_reg && (5'(rd_addr) == indice_reg)) ?
                       {rd_raw[2:0], rd_raw[3]} : rd_raw;
`else
    assign press_val = rd_raw;
`endif

    // The buffer read feeds the botoes register directly, so the press value is registered.
    always_ff @(posedge clock) begin
        if (wr_en)
            buffer_mem[wr_addr] <= wr_data;
    end
    assign rd_raw = buffer_mem[rd_addr];

    assign leds_edge = (leds_prev_reg == 4'd0) && (leds_reg != 4'd0);
    assign vez_edge  = vez_reg && !vez_prev_reg;
    assign rep_inc   = (rep_reg < MAX_IDX) ? rep_reg + IW'(1) : rep_reg;

    always_comb begin
        state_next  = state_reg;
        timer_next  = timer_reg;
        cap_next    = cap_reg;
        rep_next    = rep_reg;
        botoes_next = botoes_reg;
        erro_next   = erro_reg;
        modo_next   = modo_reg;
        wr_en       = 1'b0;
        wr_addr     = cap_reg[AW-1:0];
        wr_data     = leds_reg;
        rd_addr     = '0;

        if (!habilitar_reg) begin
            state_next  = OCIOSO;
            botoes_next = 4'd0;
            timer_next  = '0;
            cap_next    = '0;
            rep_next    = '0;
        end else begin
            case (state_reg)
                OCIOSO: begin
                    modo_next   = modo2_in_reg;
                    cap_next    = '0;
                    rep_next    = '0;
                    timer_next  = '0;
                    botoes_next = 4'd0;
                    state_next  = CAPTURA;
                end
                CAPTURA: begin
                    botoes_next = 4'd0;
                    if (leds_edge) begin
                        if (is_one_hot(leds_reg) && (cap_reg < MAX_IDX)) begin
                            wr_en    = 1'b1;
                            cap_next = cap_reg + IW'(1);
                        end else begin
                            erro_next = 1'b1;
                        end
                    end
                    if (vez_edge) begin
                        rep_next   = '0;
                        timer_next = '0;
                        if (cap_reg != '0) begin
                            state_next  = PRESSIONA;
                            botoes_next = press_val;
                        end else if (modo_reg) begin
                            state_next = ESPERA_NOVA;
                        end
                    end
                end
                PRESSIONA: begin
                    if (timer_reg == HOLD_END) begin
                        timer_next  = '0;
                        botoes_next = 4'd0;
                        state_next  = INTERVALO;
                    end else begin
                        timer_next = timer_reg + TW'(1);
                    end
                end
                INTERVALO: begin
                    if (timer_reg == GAP_END) begin
                        timer_next = '0;
                        rep_next   = rep_inc;
                        if (rep_inc < cap_reg) begin
                            rd_addr     = rep_inc[AW-1:0];
                            botoes_next = press_val;
                            state_next  = PRESSIONA;
                        end else if (modo_reg) begin
                            state_next = ESPERA_NOVA;
                        end else begin
                            cap_next   = '0;
                            state_next = CAPTURA;
                        end
                    end else begin
                        timer_next = timer_reg + TW'(1);
                    end
                end
                ESPERA_NOVA: begin
                    if (nova_reg) begin
                        botoes_next = novo_reg;
                        timer_next  = '0;
                        state_next  = PRESSIONA_NOVA;
                    end else if (!vez_reg && !vez_prev_reg) begin
                        state_next = CAPTURA;
                    end
                end
                PRESSIONA_NOVA: begin
                    if (timer_reg == HOLD_END) begin
                        timer_next  = '0;
                        botoes_next = 4'd0;
                        state_next  = INTERVALO_NOVA;
                        if (cap_reg < MAX_IDX) begin
                            wr_en    = 1'b1;
                            wr_data  = botoes_reg;
                            cap_next = cap_reg + IW'(1);
                        end else begin
                            erro_next = 1'b1;
                        end
                    end else begin
                        timer_next = timer_reg + TW'(1);
                    end
                end
                INTERVALO_NOVA: begin
                    if (timer_reg == GAP_END) begin
                        timer_next = '0;
                        rep_next   = '0;
                        if (vez_reg) begin
                            botoes_next = press_val;
                            state_next  = PRESSIONA;
                        end else begin
                            state_next = CAPTURA;
                        end
                    end else begin
                        timer_next = timer_reg + TW'(1);
                    end
                end
                default: begin
                    state_next  = OCIOSO;
                    botoes_next = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg  <= OCIOSO;
            timer_reg  <= '0;
            cap_reg    <= '0;
            rep_reg    <= '0;
            botoes_reg <= 4'd0;
            erro_reg   <= 1'b0;
            modo_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            timer_reg  <= timer_next;
            cap_reg    <= cap_next;
            rep_reg    <= rep_next;
            botoes_reg <= botoes_next;
            erro_reg   <= erro_next;
            modo_reg   <= modo_next;
        end
    end

    // Capture states show the capture index; replay states show the replay index.
    assign db_indice    = ((state_reg == OCIOSO) || (state_reg == CAPTURA)) ? 5'(cap_reg) : 5'(rep_reg);
    assign botoes       = botoes_reg;
    assign ocupado      = (state_reg != OCIOSO);
    assign erro_captura = erro_reg;
    assign db_estado    = state_reg;

endmodule

// File: tb/tb_jogador_automatico.sv
// Directed bench for jogador_automatico: capture table, replay timing, modo2 append and interruptions.
module tb_jogador_automatico;

    localparam int GAP  = 2503;
    localparam int HOLD = 3;
    localparam int LIM  = 3000;

    logic       clock = 1'b0;
    logic       reset, habilitar, vez_jogador, nova_jogada, modo2;
    logic [3:0] leds, novo_valor, botoes, db_estado;
    logic       ocupado, erro_captura;
    logic [4:0] db_indice;
    logic       injetar_erro;
    logic [4:0] indice_erro;

    always #5 clock = ~clock;

    jogador_automatico dut (
        .clock        (clock),
        .reset        (reset),
        .habilitar    (habilitar),
        .leds         (leds),
        .vez_jogador  (vez_jogador),
        .nova_jogada  (nova_jogada),
        .modo2        (modo2),
        .novo_valor   (novo_valor),
`ifdef JOGADOR_ERRO_INJETADO_EN
        .injetar_erro (injetar_erro),
        .indice_erro  (indice_erro),
`endif
        .botoes       (botoes),
        .ocupado      (ocupado),
        .erro_captura (erro_captura),
        .db_indice    (db_indice),
        .db_estado    (db_estado)
    );

    typedef struct {
        logic [3:0] leds;
        int         erro;
        int         idx;
    } vec_t;

    vec_t       vecs [6];
    logic [3:0] exp_seq [0:15];
    int         total  = 0;
    int         passed = 0;

    task automatic check(input string name, input int got, input int expv);
        total++;
        if (got == expv) begin
            passed++;
            $display("ok   %s = %0d", name, got);
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b0;
        habilitar    = 1'b0;
        leds         = 4'd0;
        vez_jogador  = 1'b0;
        nova_jogada  = 1'b0;
        modo2        = 1'b0;
        novo_valor   = 4'd0;
        injetar_erro = 1'b0;
        indice_erro  = 5'd0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic enable(input logic m);
        modo2     = m;
        habilitar = 1'b1;
        tick();
        tick();
    endtask

    task automatic show_led(input logic [3:0] v);
        leds = v;
        tick();
        tick();
        leds = 4'd0;
        tick();
        tick();
    endtask

    task automatic wait_state(input int s, input string name);
        int n = 0;
        while (db_estado != 4'(s) && n < LIM) begin
            tick();
            n++;
        end
        check(name, int'(db_estado), s);
    endtask

    // Measures n presses: value, hold length, gap before each press (and first-press latency if lat>=0).
    task automatic replay_seq(input int n, input int lat, input string name);
        for (int k = 0; k < n; k++) begin
            int z = 0;
            int on = 0;
            while (botoes == 4'd0 && z < LIM) begin
                z++;
                tick();
            end
            if (k > 0)
                check($sformatf("%s_gap%0d", name, k), z, GAP);
            else if (lat >= 0)
                check($sformatf("%s_lat", name), z, lat);
            check($sformatf("%s_val%0d", name, k), int'(botoes), int'(exp_seq[k]));
            while (botoes != 4'd0 && on < 10) begin
                on++;
                tick();
            end
            check($sformatf("%s_hold%0d", name, k), on, HOLD);
        end
    endtask

    initial begin
        #(10 * 100000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{leds: 4'b0001, erro: 0, idx: 1};
        vecs[1] = '{leds: 4'b0100, erro: 0, idx: 2};
        vecs[2] = '{leds: 4'b1000, erro: 0, idx: 3};
        vecs[3] = '{leds: 4'b0010, erro: 0, idx: 4};
        vecs[4] = '{leds: 4'b0101, erro: 1, idx: 4};
        vecs[5] = '{leds: 4'b0001, erro: 1, idx: 5};

        // Reset state
        do_reset();
        check("rst_botoes", int'(botoes), 0);
        check("rst_ocupado", int'(ocupado), 0);
        check("rst_erro", int'(erro_captura), 0);
        check("rst_indice", int'(db_indice), 0);
        check("rst_estado", int'(db_estado), 0);

        // Capture table
        enable(1'b0);
        check("en_estado", int'(db_estado), 1);
        check("en_ocupado", int'(ocupado), 1);
        for (int i = 0; i < 6; i++) begin
            show_led(vecs[i].leds);
            check($sformatf("cap%0d_erro", i), int'(erro_captura), vecs[i].erro);
            check($sformatf("cap%0d_idx", i), int'(db_indice), vecs[i].idx);
        end

        // Buffer overflow
        do_reset();
        enable(1'b0);
        for (int i = 0; i < 16; i++) show_led(4'(1 << (i % 4)));
        check("ovf_idx16", int'(db_indice), 16);
        check("ovf_erro0", int'(erro_captura), 0);
        show_led(4'b0010);
        check("ovf_idx17", int'(db_indice), 16);
        check("ovf_erro1", int'(erro_captura), 1);

        // Modo1, three rounds
        do_reset();
        enable(1'b0);
        exp_seq[0] = 4'b0001;
        exp_seq[1] = 4'b0100;
        exp_seq[2] = 4'b1000;
        for (int r = 1; r <= 3; r++) begin
            for (int i = 0; i < r; i++) show_led(exp_seq[i]);
            if (r == 1) check("m1_indice", int'(db_indice), 1);
            vez_jogador = 1'b1;
            replay_seq(r, 2, $sformatf("m1r%0d", r));
            check($sformatf("m1r%0d_intervalo", r), int'(db_estado), 3);
            vez_jogador = 1'b0;
            wait_state(1, $sformatf("m1r%0d_captura", r));
            check($sformatf("m1r%0d_capclr", r), int'(db_indice), 0);
        end

        // Modo2
        do_reset();
        enable(1'b1);
        show_led(4'b0010);
        vez_jogador = 1'b1;
        exp_seq[0] = 4'b0010;
        replay_seq(1, 2, "m2r1");
        wait_state(4, "m2_espera1");
        novo_valor  = 4'b1000;
        nova_jogada = 1'b1;
        tick();
        check("m2_nova_lat1", int'(botoes), 0);
        tick();
        nova_jogada = 1'b0;
        exp_seq[0] = 4'b1000;
        exp_seq[1] = 4'b0010;
        exp_seq[2] = 4'b1000;
        replay_seq(3, -1, "m2r2");
        wait_state(4, "m2_espera2");
        novo_valor  = 4'b0001;
        nova_jogada = 1'b1;
        tick();
        tick();
        nova_jogada = 1'b0;
        exp_seq[0] = 4'b0001;
        replay_seq(1, -1, "m2nova2");
        check("m2_intervalo_nova", int'(db_estado), 6);
        vez_jogador = 1'b0;
        wait_state(1, "m2_captura");
        check("m2_cap3", int'(db_indice), 3);

        // Asynchronous reset mid-press
        do_reset();
        enable(1'b0);
        show_led(4'b0100);
        vez_jogador = 1'b1;
        tick();
        tick();
        check("ar_press", int'(botoes), 4);
        check("ar_estado2", int'(db_estado), 2);
        #2 reset = 1'b0;
        #1;
        check("ar_botoes0", int'(botoes), 0);
        check("ar_estado0", int'(db_estado), 0);
        reset       = 1'b1;
        vez_jogador = 1'b0;
        tick();

        // habilitar dropped mid-INTERVALO
        do_reset();
        enable(1'b0);
        show_led(4'b0001);
        vez_jogador = 1'b1;
        exp_seq[0] = 4'b0001;
        replay_seq(1, 2, "hab");
        check("hab_intervalo", int'(db_estado), 3);
        habilitar = 1'b0;
        tick();
        tick();
        check("hab_estado0", int'(db_estado), 0);
        check("hab_ocupado0", int'(ocupado), 0);
        check("hab_botoes0", int'(botoes), 0);
        vez_jogador = 1'b0;

`ifdef JOGADOR_ERRO_INJETADO_EN
        do_reset();
        enable(1'b0);
        show_led(4'b0001);
        show_led(4'b0100);
        injetar_erro = 1'b1;
        indice_erro  = 5'd1;
        vez_jogador  = 1'b1;
        exp_seq[0] = 4'b0001;
        exp_seq[1] = 4'b1000;
        replay_seq(2, 2, "inj");
        vez_jogador = 1'b0;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
